// File: rtl/aes_pkg.sv
// Shared AES-128 definitions: FSM states, round constants, S-box and the
// byte-level round transforms used by the round unit.
package aes_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ROUND = 2'd1,
    DONE  = 2'd2
  } aes_fsm_e;

  localparam logic [3:0] ROUND_CNT = 4'd10;

  // Index 0 is the leftmost byte, so SBOX[b] is a direct lookup.
  localparam logic [0:255][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] rcon(input logic [3:0] r);
    case (r)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [127:0] subBytes128(input logic [127:0] s);
    logic [127:0] o;
    for (int i = 0; i < 16; i++) o[8*i +: 8] = SBOX[s[8*i +: 8]];
    return o;
  endfunction

  // Byte n of the block sits at [127-8n -: 8]; column c holds bytes 4c..4c+3.
  function automatic logic [127:0] shift128(input logic [127:0] s);
    logic [127:0] o;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[127-8*(r+4*c) -: 8] = s[127-8*(r+4*((c+r)%4)) -: 8];
    return o;
  endfunction

  function automatic logic [127:0] mixCol128(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0] a0, a1, a2, a3;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127-32*c -: 8];
      a1 = s[119-32*c -: 8];
      a2 = s[111-32*c -: 8];
      a3 = s[103-32*c -: 8];
      o[127-32*c -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
      o[119-32*c -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
      o[111-32*c -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
      o[103-32*c -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
    end
    return o;
  endfunction

  function automatic logic [127:0] expandKey(input logic [127:0] k, input logic [7:0] rc);
    logic [31:0] w0, w1, w2, w3, t;
    t  = {k[23:0], k[31:24]};
    t  = {SBOX[t[31:24]], SBOX[t[23:16]], SBOX[t[15:8]], SBOX[t[7:0]]} ^ {rc, 24'h0};
    w0 = k[127:96] ^ t;
    w1 = k[95:64] ^ w0;
    w2 = k[63:32] ^ w1;
    w3 = k[31:0] ^ w2;
    return {w0, w1, w2, w3};
  endfunction

  function automatic logic [127:0] addRoundKey(input logic [127:0] s, input logic [127:0] k);
    return s ^ k;
  endfunction

endpackage

// File: rtl/aes_round_unit.sv
// One combinational AES-128 encryption round plus the matching key-schedule step.
module aes_round_unit
  import aes_pkg::*;
(
  input  logic [127:0] state,
  input  logic [127:0] rkey,
  input  logic [7:0]   rcon_i,
  input  logic         last_rnd,
  output logic [127:0] nstate,
  output logic [127:0] nkey
);

  logic [127:0] sb, sr, mc;

  assign sb     = subBytes128(state);
  assign sr     = shift128(sb);
  assign mc     = last_rnd ? sr : mixCol128(sr);
  assign nkey   = expandKey(rkey, rcon_i);
  assign nstate = addRoundKey(mc, nkey);

endmodule

// File: rtl/aes_iter_ctrl.sv
// Iterative AES-128 encryptor: RPC chained round units per clock, valid/ready
// request and result handshakes, result held in DONE until taken.
module aes_iter_ctrl
  import aes_pkg::*;
#(
  parameter int RPC = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] plaintext,
  input  logic [127:0] key,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] ciphertext,
  output logic         busy
);

  if (!(RPC == 1 || RPC == 2 || RPC == 5 || RPC == 10)) begin : g_bad_rpc
    $error("aes_iter_ctrl: RPC must be 1, 2, 5 or 10");
  end

  localparam logic [3:0] STEP = 4'(RPC);

  aes_fsm_e     fsm;
  logic [3:0]   cnt;
  logic [127:0] st, rk;
  logic [3:0]   last;

  logic [RPC:0][127:0] st_c, rk_c;

  assign st_c[0]    = st;
  assign rk_c[0]    = rk;
  assign last       = cnt + STEP - 4'd1;
  assign ciphertext = st;

  for (genvar i = 0; i < RPC; i++) begin : g_rnd
    logic [3:0] rnum;
    assign rnum = cnt + 4'(i);
    aes_round_unit u_rnd (
      .state    (st_c[i]),
      .rkey     (rk_c[i]),
      .rcon_i   (rcon(rnum)),
      .last_rnd (rnum == ROUND_CNT),
      .nstate   (st_c[i+1]),
      .nkey     (rk_c[i+1])
    );
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fsm       <= IDLE;
      cnt       <= 4'd0;
      st        <= '0;
      rk        <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (fsm)
        IDLE: begin
          if (in_valid && in_ready) begin
            st       <= plaintext ^ key;
            rk       <= key;
            cnt      <= 4'd1;
            fsm      <= ROUND;
            in_ready <= 1'b0;
            busy     <= 1'b1;
          end
        end
        ROUND: begin
          st <= st_c[RPC];
          rk <= rk_c[RPC];
          // Counter parks at 10 once the final round lands; it never wraps.
          if (last >= ROUND_CNT) begin
            cnt       <= ROUND_CNT;
            fsm       <= DONE;
            out_valid <= 1'b1;
          end else begin
            cnt <= cnt + STEP;
          end
        end
        DONE: begin
          if (out_ready) begin
            fsm       <= IDLE;
            cnt       <= 4'd0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            in_ready  <= 1'b1;
          end
        end
        default: begin
          fsm       <= IDLE;
          cnt       <= 4'd0;
          out_valid <= 1'b0;
          busy      <= 1'b0;
          in_ready  <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_aes_iter_ctrl.sv
// Scoreboard bench for aes_iter_ctrl: known-answer vectors, latency, backpressure,
// input isolation, mid-operation reset, back-to-back traffic and RPC variants.
module tb_aes_iter_ctrl;

  localparam int RPC = 1;
  localparam int LAT = 10 / RPC + 1;

  localparam logic [127:0] KA = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] PA = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CA = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] KB = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] PB = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] CB = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] KZ = 128'h0;
  localparam logic [127:0] PZ = 128'h0;
  localparam logic [127:0] CZ = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic in_valid = 1'b0;
  logic out_ready = 1'b0;
  logic in_ready, out_valid, busy;
  logic [127:0] plaintext = '0;
  logic [127:0] key = '0;
  logic [127:0] ciphertext;

  int errors = 0;
  int checks = 0;
  logic [127:0] sb[$];

  always #5 clk = ~clk;

  aes_iter_ctrl #(.RPC(RPC)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .plaintext  (plaintext),
    .key        (key),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .ciphertext (ciphertext),
    .busy       (busy)
  );

  localparam int NAUX = 3;
  localparam int AUX_RPC [NAUX] = '{2, 5, 10};
  logic aux_iv = 1'b0;
  logic [NAUX-1:0] aux_ir, aux_ov, aux_busy;
  logic [127:0] aux_ct [NAUX];

  for (genvar g = 0; g < NAUX; g++) begin : g_aux
    aes_iter_ctrl #(.RPC(AUX_RPC[g])) u_aux (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_valid   (aux_iv),
      .in_ready   (aux_ir[g]),
      .plaintext  (plaintext),
      .key        (key),
      .out_valid  (aux_ov[g]),
      .out_ready  (1'b1),
      .ciphertext (aux_ct[g]),
      .busy       (aux_busy[g])
    );
  end

  // Called at a negedge; returns at the negedge of the first ROUND cycle.
  task automatic accept(input logic [127:0] p, input logic [127:0] k,
                        input logic [127:0] exp, output bit ok);
    ok = 1'b0;
    plaintext = p;
    key = k;
    in_valid = 1'b1;
    for (int i = 0; i < 40 && !ok; i++) begin
      if (in_ready) begin
        ok = 1'b1;
        sb.push_back(exp);
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b want=0", busy); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
    checks++; if (ciphertext !== 128'h0) begin errors++; $display("FAIL reset_state got=%h want=0", ciphertext); end
    checks++; if (aux_ir !== 3'b111) begin errors++; $display("FAIL reset_aux_in_ready got=%b want=111", aux_ir); end
  endtask

  task automatic test_vector(input logic [127:0] p, input logic [127:0] k, input logic [127:0] exp);
    bit ok;
    int cyc;
    logic [127:0] want;
    out_ready = 1'b1;
    accept(p, k, exp, ok);
    checks++; if (!ok) begin errors++; $display("FAIL vec_accept got=timeout want=accepted"); end
    checks++; if (busy !== 1'b1 || in_ready !== 1'b0) begin errors++; $display("FAIL vec_round_flags got busy=%b in_ready=%b want busy=1 in_ready=0", busy, in_ready); end
    cyc = 1;
    while (!out_valid && cyc < 40) begin @(negedge clk); cyc++; end
    checks++; if (cyc != LAT) begin errors++; $display("FAIL vec_latency got=%0d want=%0d", cyc, LAT); end
    want = (sb.size() > 0) ? sb.pop_front() : 128'hx;
    checks++; if (ciphertext !== want) begin errors++; $display("FAIL vec_cipher got=%h want=%h", ciphertext, want); end
    @(negedge clk);
    checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin errors++; $display("FAIL vec_return_idle got in_ready=%b out_valid=%b want 1/0", in_ready, out_valid); end
  endtask

  task automatic test_backpressure();
    bit ok;
    int cyc;
    logic [127:0] want;
    out_ready = 1'b0;
    accept(PB, KB, CB, ok);
    cyc = 1;
    while (!out_valid && cyc < 40) begin @(negedge clk); cyc++; end
    checks++; if (!out_valid) begin errors++; $display("FAIL bp_wait got out_valid=0 want=1"); end
    want = (sb.size() > 0) ? sb.pop_front() : 128'hx;
    for (int i = 0; i < 20; i++) begin
      checks++;
      if (out_valid !== 1'b1 || ciphertext !== want || in_ready !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold_%0d got ov=%b ir=%b ct=%h want ov=1 ir=0 ct=%h", i, out_valid, in_ready, ciphertext, want);
      end
      @(negedge clk);
    end
    out_ready = 1'b1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_hs_cycle_in_ready got=%b want=0", in_ready); end
    @(negedge clk);
    checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin errors++; $display("FAIL bp_release got ir=%b ov=%b want 1/0", in_ready, out_valid); end
  endtask

  task automatic test_ignore_inputs();
    bit ok;
    int cyc, extra;
    logic [127:0] want;
    out_ready = 1'b1;
    accept(PZ, KZ, CZ, ok);
    cyc = 1;
    extra = 0;
    while (!out_valid && cyc < 40) begin
      in_valid  = 1'($urandom);
      plaintext = {$urandom, $urandom, $urandom, $urandom};
      key       = {$urandom, $urandom, $urandom, $urandom};
      if (in_valid && in_ready) extra++;
      @(negedge clk);
      cyc++;
    end
    in_valid = 1'b0;
    want = (sb.size() > 0) ? sb.pop_front() : 128'hx;
    checks++; if (ciphertext !== want) begin errors++; $display("FAIL ign_cipher got=%h want=%h", ciphertext, want); end
    checks++; if (extra != 0) begin errors++; $display("FAIL ign_extra_accept got=%0d want=0", extra); end
    checks++; if (cyc != LAT) begin errors++; $display("FAIL ign_latency got=%0d want=%0d", cyc, LAT); end
    @(negedge clk);
  endtask

  task automatic test_reset_midround();
    bit ok;
    int cyc, stale;
    logic [127:0] want;
    out_ready = 1'b1;
    accept(PB, KB, CB, ok);
    for (int i = 1; i < (4 / RPC) + 1; i++) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    sb.delete();
    checks++; if (busy !== 1'b0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL rst_mid_flags got busy=%b ov=%b ir=%b want 0/0/1", busy, out_valid, in_ready); end
    stale = 0;
    repeat (15) begin if (out_valid) stale++; @(negedge clk); end
    checks++; if (stale != 0) begin errors++; $display("FAIL rst_mid_stale got=%0d want=0", stale); end
    accept(PA, KA, CA, ok);
    cyc = 1;
    while (!out_valid && cyc < 40) begin @(negedge clk); cyc++; end
    want = (sb.size() > 0) ? sb.pop_front() : 128'hx;
    checks++; if (ciphertext !== want || cyc != LAT) begin errors++; $display("FAIL rst_mid_result got ct=%h lat=%0d want ct=%h lat=%0d", ciphertext, cyc, want, LAT); end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    logic [127:0] vp [3] = '{PA, PB, PZ};
    logic [127:0] vk [3] = '{KA, KB, KZ};
    logic [127:0] vc [3] = '{CA, CB, CZ};
    int got, cyc;
    bit hs_prev;
    out_ready = 1'b1;
    got = 0;
    hs_prev = 1'b0;
    fork
      begin
        for (int j = 0; j < 3; j++) begin
          bit ok;
          accept(vp[j], vk[j], vc[j], ok);
          checks++; if (!ok) begin errors++; $display("FAIL b2b_accept_%0d got=timeout want=accepted", j); end
        end
      end
      begin
        logic [127:0] want;
        cyc = 0;
        while ((got < 3 || hs_prev) && cyc < 200) begin
          @(negedge clk);
          cyc++;
          if (hs_prev) begin
            checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_in_ready_%0d got=%b want=1", got, in_ready); end
            hs_prev = 1'b0;
          end
          if (out_valid && out_ready) begin
            want = (sb.size() > 0) ? sb.pop_front() : 128'hx;
            checks++; if (ciphertext !== want) begin errors++; $display("FAIL b2b_cipher_%0d got=%h want=%h", got, ciphertext, want); end
            got++;
            hs_prev = 1'b1;
          end
        end
      end
    join
    checks++; if (got != 3) begin errors++; $display("FAIL b2b_count got=%0d want=3", got); end
    @(negedge clk);
  endtask

  task automatic test_rpc_variants();
    int lat [NAUX];
    plaintext = PB;
    key = KB;
    aux_iv = 1'b1;
    @(negedge clk);
    aux_iv = 1'b0;
    plaintext = '0;
    key = '0;
    for (int g = 0; g < NAUX; g++) lat[g] = 0;
    for (int cyc = 1; cyc <= 20; cyc++) begin
      for (int g = 0; g < NAUX; g++) begin
        if (aux_ov[g] && lat[g] == 0) begin
          lat[g] = cyc;
          checks++; if (aux_ct[g] !== CB) begin errors++; $display("FAIL rpc%0d_cipher got=%h want=%h", AUX_RPC[g], aux_ct[g], CB); end
        end
      end
      @(negedge clk);
    end
    for (int g = 0; g < NAUX; g++) begin
      checks++; if (lat[g] != 10 / AUX_RPC[g] + 1) begin errors++; $display("FAIL rpc%0d_latency got=%0d want=%0d", AUX_RPC[g], lat[g], 10 / AUX_RPC[g] + 1); end
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_rpc_variants();
    test_vector(PA, KA, CA);
    test_vector(PB, KB, CB);
    test_backpressure();
    test_ignore_inputs();
    test_reset_midround();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
